toggle_en_gen: RTL and testbench
================================

TOGGLE_EN_GEN -- requirements
Module: toggle_en_gen

Interface
REQ-001 The block SHALL have parameter DIV_W, default 8, meaning the width of the period field.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the pulse-count field.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port cfg_valid  input  1  configuration offered.
REQ-006 The block SHALL have port cfg_ready  output  1  configuration accepted when high together with cfg_valid.
REQ-007 The block SHALL have port cfg_div  input  DIV_W  enable period in cycles.
REQ-008 The block SHALL have port cfg_cnt  input  CNT_W  number of enable pulses per run; 0 means continuous.
REQ-009 The block SHALL have port start  input  1  begin a run.
REQ-010 The block SHALL have port stop  input  1  abort a run.
REQ-011 The block SHALL have port en  output  1  registered one-cycle enable pulse driving the downstream toggle flop's EN.
REQ-012 The block SHALL have port busy  output  1  high while in RUN.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse on run completion.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE, and all outputs SHALL be registered.
REQ-015 cfg_ready SHALL be high in IDLE and DONE and low in RUN; a handshake SHALL latch div_reg and cnt_reg, and cfg_valid in RUN SHALL stall without effect.
REQ-016 Effective period P SHALL be div_reg, with div_reg=0 treated as 1.
REQ-017 start sampled in IDLE or DONE SHALL move the FSM to RUN, load the divider with P-1 and clear the pulse counter.
REQ-018 In RUN, en SHALL be high exactly P cycles after the start-sampling edge and then every P cycles, for one cycle each; P=1 SHALL give en high every cycle.
REQ-019 When cnt_reg≠0, the edge that emits pulse number cnt_reg SHALL move the FSM to DONE; no further en pulse SHALL occur.
REQ-020 DONE SHALL last one cycle with done=1, then move to IDLE, unless start is sampled in DONE, in which case the FSM SHALL return to RUN.
REQ-021 A cfg handshake and start on the same edge SHALL make the run use the newly latched values.
REQ-022 start in RUN SHALL be ignored.
REQ-023 stop in RUN SHALL force IDLE at the next edge with en=0 at that edge, even if a pulse was due, and done SHALL stay 0.
REQ-024 stop and start together in IDLE or DONE SHALL give IDLE, with stop taking priority.
REQ-025 The divider and pulse counter SHALL wrap at no point: the divider SHALL reload at P-1 after each pulse, and the pulse counter SHALL saturate when cnt_reg=0.

Reset
REQ-026 rst high SHALL asynchronously force IDLE, en=0, busy=0, done=0, cfg_ready=1, div_reg=1, cnt_reg=0, divider=0, pulse counter=0, and phase_q=0 when phase_q is present.
REQ-027 rst asserted mid-run SHALL abort the run without producing a done pulse, and operation SHALL resume on the first edge after release.

Configuration
REQ-028 Macro TOGGLE_EN_GEN_PHASE_EN SHALL control the phase_q output.
- Defined: the block SHALL add output phase_q  1  a mirror of the downstream toggle flop state; it toggles on the edge after each cycle with en=1 and clears only on rst.
- Undefined: phase_q SHALL be absent and no mirror register SHALL exist; all other behaviour SHALL be identical.

Structure
REQ-029 Package teg_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default DIV_W/CNT_W constants.
REQ-030 The reloadable down-counter SHALL be the sub-module teg_divcnt, with inputs load, load_val and dec and output zero; the FSM and pulse counter SHALL stay in the top level.

Verification
REQ-031 Configure div=3, cnt=4, then start at cycle 0 -> en high at cycles 3, 6, 9 and 12, done high at cycle 13, busy low from cycle 13.
REQ-032 Configure div=0, cnt=5, then start -> en high for 5 consecutive cycles starting 1 cycle after start, then done.
REQ-033 Configure div=4, cnt=0, start, then stop 2 cycles before the 3rd pulse is due -> exactly 2 en pulses, done never asserted, FSM in IDLE.
REQ-034 Assert cfg_valid with div=2 in RUN -> cfg_ready=0 and the period is unchanged; the handshake completes in DONE and the next run uses a period of 2.
REQ-035 Assert rst mid-run after 1 pulse -> en, busy and done all 0 immediately; with TOGGLE_EN_GEN_PHASE_EN defined, phase_q=0.
REQ-036 With TOGGLE_EN_GEN_PHASE_EN defined, configure div=2, cnt=3 and start -> phase_q sequence 0→1→0→1, matching a reference toggle flop driven by en.

Source files
------------

// File: rtl/teg_pkg.sv
// Shared types and default widths for the toggle enable generator.
package teg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_DIV_W = 8;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/teg_divcnt.sv
// Reloadable down-counter: load has priority over dec, zero flags an expired count.
module teg_divcnt #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - DIV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/toggle_en_gen.sv
// Periodic one-cycle enable generator with optional pulse count and stop/abort.
// Optional feature: TOGGLE_EN_GEN_PHASE_EN adds phase_q, a mirror of the downstream toggle flop.
module toggle_en_gen
  import teg_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_cnt,
  input  logic             start,
  input  logic             stop,
  output logic             en,
  output logic             busy,
  output logic             done
`ifdef TOGGLE_EN_GEN_PHASE_EN
  ,
  output logic             phase_q
`endif
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             en_q, en_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, done_q;

  logic             hs;
  logic [DIV_W-1:0] eff_div;
  logic [DIV_W-1:0] reload;
  logic [CNT_W-1:0] pcnt_inc;
  logic             ld, dec, zero;

  // A handshake on the start edge must feed the fresh period straight into the divider.
  assign hs       = cfg_valid && rdy_q;
  assign eff_div  = hs ? cfg_div : div_q;
  assign reload   = (eff_div == '0) ? '0 : eff_div - DIV_W'(1);
  assign pcnt_inc = pcnt_q + CNT_W'(1);

  teg_divcnt #(.DIV_W(DIV_W)) u_divcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (reload),
    .dec      (dec),
    .zero     (zero)
  );

  always_comb begin
    state_d = state_q;
    div_d   = hs ? cfg_div : div_q;
    cnt_d   = hs ? cfg_cnt : cnt_q;
    pcnt_d  = pcnt_q;
    en_d    = 1'b0;
    ld      = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
          ld      = 1'b1;
          pcnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (zero) begin
          en_d = 1'b1;
          ld   = 1'b1;
          // Continuous runs park the pulse counter at all-ones instead of wrapping.
          if (pcnt_q != '1) pcnt_d = pcnt_inc;
          if ((cnt_q != '0) && (pcnt_inc == cnt_q)) state_d = DONE;
        end else begin
          dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d != RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= DIV_W'(1);
      cnt_q   <= '0;
      pcnt_q  <= '0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      busy_q  <= (state_q == RUN);
      done_q  <= (state_q == DONE);
    end
  end

`ifdef TOGGLE_EN_GEN_PHASE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= 1'b0;
    else     phase_q <= phase_q ^ en_q;
  end
`endif

  assign en        = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_ready = rdy_q;

endmodule

// File: tb/tb_toggle_en_gen.sv
// Directed bench for toggle_en_gen with a per-cycle expectation queue.
module tb_toggle_en_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_div;
  logic [7:0] cfg_cnt;
  logic       start;
  logic       stop;
  logic       en;
  logic       busy;
  logic       done;
`ifdef TOGGLE_EN_GEN_PHASE_EN
  logic       phase_q;
  logic       ref_ph;
`endif

  typedef struct {
    logic en;
    logic busy;
    logic done;
    logic rdy;
  } exp_t;

  exp_t sb[$];
  int   ncmp  = 0;
  int   nfail = 0;

  toggle_en_gen #(.DIV_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_cnt   (cfg_cnt),
    .start     (start),
    .stop      (stop),
    .en        (en),
    .busy      (busy),
    .done      (done)
`ifdef TOGGLE_EN_GEN_PHASE_EN
    ,
    .phase_q   (phase_q)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Caller sets start (and optionally a cfg handshake) before the call; that edge is cycle 0.
  // p: period, n: pulse count (0 = continuous), stop_at: edge sampling stop (0 = none),
  // new_div: if >= 0, offer that period on cfg from cycle 0 onward (left for the caller to drop).
  task automatic run(input string name, input int p, input int n, input int stop_at,
                     input int ncyc, input int new_div);
    int   last;
    exp_t e;
    exp_t o;
    if (n != 0)            last = n * p;
    else if (stop_at != 0) last = stop_at;
    else                   last = 1 << 30;
    for (int k = 0; k <= ncyc; k++) begin
      e.en   = (k > 0) && (k % p == 0) && ((n != 0) ? (k <= last) : (k < last));
      e.busy = (k >= 1) && (k - 1 < last);
      e.done = (n != 0) && (k == last + 1);
      e.rdy  = !(k < last);
      sb.push_back(e);
      if (stop_at != 0 && k == stop_at) stop = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      if (k == 0) begin
        cfg_valid = 1'b0;
        if (new_div >= 0) begin
          cfg_valid = 1'b1;
          cfg_div   = 8'(new_div);
        end
      end
      o = sb.pop_front();
      chk($sformatf("%s en@%0d", name, k), en, o.en);
      chk($sformatf("%s busy@%0d", name, k), busy, o.busy);
      chk($sformatf("%s done@%0d", name, k), done, o.done);
      chk($sformatf("%s cfg_ready@%0d", name, k), cfg_ready, o.rdy);
`ifdef TOGGLE_EN_GEN_PHASE_EN
      chk($sformatf("%s phase@%0d", name, k), phase_q, ref_ph);
      if (o.en) ref_ph = ~ref_ph;
`endif
    end
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_cnt   = '0;
    start     = 1'b0;
    stop      = 1'b0;
`ifdef TOGGLE_EN_GEN_PHASE_EN
    ref_ph    = 1'b0;
`endif
    step();
    step();
    chk("reset en", en, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset cfg_ready", cfg_ready, 1'b1);
`ifdef TOGGLE_EN_GEN_PHASE_EN
    chk("reset phase", phase_q, 1'b0);
`endif
    rst = 1'b0;
    step();

    // div=3 cnt=4 configured first, then started
    cfg_valid = 1'b1;
    cfg_div   = 8'd3;
    cfg_cnt   = 8'd4;
    step();
    chk("cfg idle ready", cfg_ready, 1'b1);
    chk("cfg idle busy", busy, 1'b0);
    cfg_valid = 1'b0;
    start     = 1'b1;
    run("d3c4", 3, 4, 0, 15, -1);

    // div=0 cnt=5 configured on the start edge: en every cycle
    cfg_valid = 1'b1;
    cfg_div   = 8'd0;
    cfg_cnt   = 8'd5;
    start     = 1'b1;
    run("d0c5", 1, 5, 0, 8, -1);

    // div=4 continuous, stop two cycles before the third pulse
    cfg_valid = 1'b1;
    cfg_div   = 8'd4;
    cfg_cnt   = 8'd0;
    start     = 1'b1;
    run("d4stop", 4, 0, 10, 15, -1);

    // cfg offered during RUN stalls, completes in DONE
    cfg_valid = 1'b1;
    cfg_div   = 8'd3;
    cfg_cnt   = 8'd2;
    start     = 1'b1;
    run("d3stall", 3, 2, 0, 7, 2);
    cfg_valid = 1'b0;
    start     = 1'b1;
    run("d2after", 2, 2, 0, 6, -1);

    // reset mid-run while a pulse is showing
    cfg_valid = 1'b1;
    cfg_div   = 8'd3;
    cfg_cnt   = 8'd0;
    start     = 1'b1;
    run("d3rst", 3, 0, 0, 3, -1);
    rst = 1'b1;
    #1;
    chk("midrst en", en, 1'b0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst cfg_ready", cfg_ready, 1'b1);
`ifdef TOGGLE_EN_GEN_PHASE_EN
    chk("midrst phase", phase_q, 1'b0);
    ref_ph = 1'b0;
`endif
    #2;
    rst   = 1'b0;
    // reset period is 1, so a bare start pulses every cycle
    start = 1'b1;
    run("postrst", 1, 0, 3, 5, -1);

`ifdef TOGGLE_EN_GEN_PHASE_EN
    cfg_valid = 1'b1;
    cfg_div   = 8'd2;
    cfg_cnt   = 8'd3;
    start     = 1'b1;
    run("phase", 2, 3, 0, 8, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
